// File: rtl/aes_pkg.sv
// Shared types and constants for the sbox arbiter slice.
package aes_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BURST_CNT_W = 4;

  localparam logic REQ_ENC = 1'b0;
  localparam logic REQ_KEY = 1'b1;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_ENC = 2'd1,
    OWN_KEY = 2'd2
  } state_t;

endpackage

// File: rtl/aes_sbox_arbiter_if.sv
// Request/grant/result bundle between the cipher core (master) and the sbox arbiter (slave).
interface aes_sbox_arbiter_if;
  import aes_pkg::*;

  logic  enc_req;
  word_t enc_word;
  logic  enc_last;
  logic  enc_gnt;
  logic  enc_rvalid;
  word_t enc_rdata;

  logic  key_req;
  word_t key_word;
  logic  key_last;
  logic  key_gnt;
  logic  key_rvalid;
  word_t key_rdata;

  modport master (
    output enc_req, enc_word, enc_last, key_req, key_word, key_last,
    input  enc_gnt, enc_rvalid, enc_rdata, key_gnt, key_rvalid, key_rdata
  );

  modport slave (
    input  enc_req, enc_word, enc_last, key_req, key_word, key_last,
    output enc_gnt, enc_rvalid, enc_rdata, key_gnt, key_rvalid, key_rdata
  );

endinterface

// File: rtl/aes_sbox.sv
// Four parallel AES forward S-box lookups on a 32-bit word (combinational).
module aes_sbox (
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign new_sboxw = {SBOX[sboxw[31:24]], SBOX[sboxw[23:16]],
                      SBOX[sboxw[15:8]],  SBOX[sboxw[7:0]]};

endmodule

// File: rtl/aes_sbox_arbiter.sv
// Shares one 4-byte sbox between the round datapath (ENC) and key expansion (KEY)
// with burst locking, round-robin priority and an overrun watchdog.
module aes_sbox_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned KEY_FIRST = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  aes_sbox_arbiter_if.slave  bus,
  output logic               err_overrun
);

  state_t                 state_q, state_d;
  logic                   prio_q, prio_d;
  logic [BURST_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                   err_q, err_d;
  logic                   enc_gnt_c, key_gnt_c;
  logic                   winner, last_c;
  word_t                  sbox_in, sbox_out;
  logic                   enc_rvalid_q, key_rvalid_q;
  word_t                  enc_rdata_q, key_rdata_q;

  // Ownership, priority and burst accounting.
  always_comb begin
    enc_gnt_c = 1'b0;
    key_gnt_c = 1'b0;
    winner    = REQ_ENC;
    last_c    = 1'b0;
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    cnt_inc   = cnt_q + BURST_CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_inc = BURST_CNT_W'(1);
        if (bus.enc_req && (!bus.key_req || prio_q == REQ_ENC)) enc_gnt_c = 1'b1;
        else if (bus.key_req)                                    key_gnt_c = 1'b1;
      end
      OWN_ENC: enc_gnt_c = bus.enc_req;
      OWN_KEY: key_gnt_c = bus.key_req;
      default: state_d = IDLE;
    endcase
    if (enc_gnt_c || key_gnt_c) begin
      winner = key_gnt_c ? REQ_KEY : REQ_ENC;
      last_c = key_gnt_c ? bus.key_last : bus.enc_last;
      // A word that reaches MAX_BURST without last is still processed, then ownership is revoked.
      if (last_c || cnt_inc == BURST_CNT_W'(MAX_BURST)) begin
        state_d = IDLE;
        cnt_d   = '0;
        prio_d  = ~winner;
        if (!last_c) err_d = 1'b1;
      end else begin
        state_d = (winner == REQ_KEY) ? OWN_KEY : OWN_ENC;
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'(KEY_FIRST);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Granted word feeds the sbox; zero when idle so the lookup input does not toggle.
  always_comb begin
    sbox_in = '0;
    if (enc_gnt_c)      sbox_in = bus.enc_word;
    else if (key_gnt_c) sbox_in = bus.key_word;
  end

  aes_sbox u_sbox (
    .sboxw     (sbox_in),
    .new_sboxw (sbox_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_rvalid_q <= 1'b0;
      key_rvalid_q <= 1'b0;
      enc_rdata_q  <= '0;
      key_rdata_q  <= '0;
    end else begin
      enc_rvalid_q <= enc_gnt_c;
      key_rvalid_q <= key_gnt_c;
      if (enc_gnt_c) enc_rdata_q <= sbox_out;
      if (key_gnt_c) key_rdata_q <= sbox_out;
    end
  end

  assign bus.enc_gnt    = enc_gnt_c;
  assign bus.key_gnt    = key_gnt_c;
  assign bus.enc_rvalid = enc_rvalid_q;
  assign bus.key_rvalid = key_rvalid_q;
  assign bus.enc_rdata  = enc_rdata_q;
  assign bus.key_rdata  = key_rdata_q;
  assign err_overrun    = err_q;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Directed bench for aes_sbox_arbiter: per-cycle vector table plus overrun and reset sequences.
module tb_aes_sbox_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic err_overrun;
  int   n_cmp = 0;
  int   n_err = 0;

  aes_sbox_arbiter_if bus ();

  aes_sbox_arbiter #(.KEY_FIRST(1), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] WA = 32'h00010203, SA = 32'h637c777b;
  localparam logic [31:0] WB = 32'h10111213, SB = 32'hca82c97d;
  localparam logic [31:0] WC = 32'h01020304, SC = 32'h7c777bf2;
  localparam logic [31:0] WD = 32'h5253fe7d, SD = 32'h00edbbff;
  localparam logic [31:0] WE = 32'h40506070, SE = 32'h0953d051;
  localparam logic [31:0] WF = 32'h8090a0b0, SF = 32'hcd60e0e7;
  localparam logic [31:0] WG = 32'hffeeddcc, SG = 32'h1628c14b;
  localparam logic [31:0] WZ = 32'h00000000, SZ = 32'h63636363;

  typedef struct {
    logic        er;  logic [31:0] ew;  logic el;
    logic        kr;  logic [31:0] kw;  logic kl;
    logic        eg;  logic kg;
    logic        erv; logic krv;
    logic [31:0] erd; logic [31:0] krd;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic er, input logic [31:0] ew, input logic el,
                              input logic kr, input logic [31:0] kw, input logic kl,
                              input logic eg, input logic kg, input logic erv, input logic krv,
                              input logic [31:0] erd, input logic [31:0] krd);
    vec_t v;
    v.er = er; v.ew = ew; v.el = el; v.kr = kr; v.kw = kw; v.kl = kl;
    v.eg = eg; v.kg = kg; v.erv = erv; v.krv = krv; v.erd = erd; v.krd = krd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic er, input logic [31:0] ew, input logic el,
                       input logic kr, input logic [31:0] kw, input logic kl);
    bus.enc_req = er; bus.enc_word = ew; bus.enc_last = el;
    bus.key_req = kr; bus.key_word = kw; bus.key_last = kl;
  endtask

  // Advance to the next cycle, apply inputs just after the edge, settle to mid-cycle.
  task automatic step(input logic er, input logic [31:0] ew, input logic el,
                      input logic kr, input logic [31:0] kw, input logic kl);
    @(posedge clk);
    #1;
    drive(er, ew, el, kr, kw, kl);
    #4;
  endtask

  task automatic chk_gnt(input string tag, input logic eg, input logic kg);
    chk({tag, " enc_gnt"}, 32'(bus.enc_gnt), 32'(eg));
    chk({tag, " key_gnt"}, 32'(bus.key_gnt), 32'(kg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0]  = mk(0, WZ, 0, 0, WZ, 0,  0, 0, 0, 0, 32'h0, 32'h0);
    vecs[1]  = mk(1, WB, 1, 1, WA, 1,  0, 1, 0, 0, 32'h0, 32'h0);
    vecs[2]  = mk(1, WB, 1, 1, WC, 1,  1, 0, 0, 1, 32'h0, SA);
    vecs[3]  = mk(1, WE, 1, 1, WC, 1,  0, 1, 1, 0, SB, SA);
    vecs[4]  = mk(1, WE, 1, 1, WG, 1,  1, 0, 0, 1, SB, SC);
    vecs[5]  = mk(0, WZ, 0, 0, WZ, 0,  0, 0, 1, 0, SE, SC);
    vecs[6]  = mk(0, WZ, 0, 1, WA, 1,  0, 1, 0, 0, SE, SC);
    vecs[7]  = mk(0, WZ, 0, 0, WZ, 0,  0, 0, 0, 1, SE, SA);
    vecs[8]  = mk(1, WD, 0, 1, WG, 1,  1, 0, 0, 0, SE, SA);
    vecs[9]  = mk(1, WB, 0, 1, WG, 1,  1, 0, 1, 0, SD, SA);
    vecs[10] = mk(1, WF, 0, 1, WG, 1,  1, 0, 1, 0, SB, SA);
    vecs[11] = mk(1, WZ, 1, 1, WG, 1,  1, 0, 1, 0, SF, SA);
    vecs[12] = mk(0, WZ, 0, 1, WG, 1,  0, 1, 1, 0, SZ, SA);
    vecs[13] = mk(0, WZ, 0, 0, WZ, 0,  0, 0, 0, 1, SZ, SG);
    vecs[14] = mk(1, WA, 0, 1, WC, 1,  1, 0, 0, 0, SZ, SG);
    vecs[15] = mk(0, WZ, 0, 1, WC, 1,  0, 0, 1, 0, SA, SG);
    vecs[16] = mk(0, WZ, 0, 1, WC, 1,  0, 0, 0, 0, SA, SG);
    vecs[17] = mk(0, WZ, 0, 1, WC, 1,  0, 0, 0, 0, SA, SG);
    vecs[18] = mk(1, WE, 1, 1, WC, 1,  1, 0, 0, 0, SA, SG);
    vecs[19] = mk(0, WZ, 0, 1, WC, 1,  0, 1, 1, 0, SE, SG);
    vecs[20] = mk(0, WZ, 0, 0, WZ, 0,  0, 0, 0, 1, SE, SC);

    rst = 1'b1;
    drive(0, WZ, 0, 0, WZ, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Contention, single KEY, ENC burst lock and a mid-burst gap, one vector per cycle.
    for (int i = 0; i < NV; i++) begin
      if (i == 0) #4;
      else step(vecs[i].er, vecs[i].ew, vecs[i].el, vecs[i].kr, vecs[i].kw, vecs[i].kl);
      chk_gnt($sformatf("v%0d", i), vecs[i].eg, vecs[i].kg);
      chk($sformatf("v%0d enc_rvalid", i), 32'(bus.enc_rvalid), 32'(vecs[i].erv));
      chk($sformatf("v%0d key_rvalid", i), 32'(bus.key_rvalid), 32'(vecs[i].krv));
      chk($sformatf("v%0d enc_rdata", i),  bus.enc_rdata, vecs[i].erd);
      chk($sformatf("v%0d key_rdata", i),  bus.key_rdata, vecs[i].krd);
      chk($sformatf("v%0d err_overrun", i), 32'(err_overrun), 32'h0);
    end

    // Overrun: four ENC words without last while KEY waits.
    step(1, WD, 0, 1, WA, 1); chk_gnt("ovr1", 1, 0);
    step(1, WB, 0, 1, WA, 1); chk_gnt("ovr2", 1, 0);
    chk("ovr2 enc_rdata", bus.enc_rdata, SD);
    step(1, WF, 0, 1, WA, 1); chk_gnt("ovr3", 1, 0);
    step(1, WG, 0, 1, WA, 1); chk_gnt("ovr4", 1, 0);
    chk("ovr4 err_overrun", 32'(err_overrun), 32'h0);
    step(0, WZ, 0, 1, WA, 1); chk_gnt("ovr5", 0, 1);
    chk("ovr5 err_overrun", 32'(err_overrun), 32'h1);
    chk("ovr5 enc_rvalid", 32'(bus.enc_rvalid), 32'h1);
    chk("ovr5 enc_rdata", bus.enc_rdata, SG);
    step(0, WZ, 0, 0, WZ, 0);
    chk("ovr6 key_rdata", bus.key_rdata, SA);
    chk("ovr6 err_overrun", 32'(err_overrun), 32'h1);
    step(0, WZ, 0, 0, WZ, 0);
    chk("ovr7 err_overrun", 32'(err_overrun), 32'h1);

    // Reset after two ENC burst words.
    step(1, WD, 0, 0, WZ, 0); chk_gnt("rst1", 1, 0);
    step(1, WB, 0, 0, WZ, 0); chk_gnt("rst2", 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, WZ, 0, 0, WZ, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, WC, 1, 1, WA, 1);
    #4;
    chk("rst4 enc_rvalid", 32'(bus.enc_rvalid), 32'h0);
    chk("rst4 enc_rdata", bus.enc_rdata, 32'h0);
    chk("rst4 key_rdata", bus.key_rdata, 32'h0);
    chk("rst4 err_overrun", 32'(err_overrun), 32'h0);
    chk_gnt("rst4", 0, 1);
    step(1, WC, 1, 0, WZ, 0); chk_gnt("rst5", 1, 0);
    chk("rst5 key_rdata", bus.key_rdata, SA);
    step(0, WZ, 0, 0, WZ, 0);
    chk("rst6 enc_rvalid", 32'(bus.enc_rvalid), 32'h1);
    chk("rst6 enc_rdata", bus.enc_rdata, SC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
